mc_ctrl: RTL and testbench

Multi-cycle main controller feeding the CPU datapath. It decodes the 6-bit opcode returned by the datapath and sequences each instruction through IF/ID/EXE/MEM/WB phases. It drives every datapath control input plus the PC and IR write enables. It also keeps a retired-instruction count and a sticky illegal-opcode flag.

---
 rtl/mc_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mc_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle main controller: IF/ID/EXE/MEM/WB sequencing and datapath control decode
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       OPcode,
  input  logic             hold,
  output logic             PCWr,
  output logic             IRWr,
  output logic             REgDst,
  output logic             SIgn,
  output logic             JUmp,
  output logic             BRanch,
  output logic             MEmtoReg,
  output logic [2:0]       ALUOP,
  output logic             MEmWrite,
  output logic             ALUSRc,
  output logic             REgWrite,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             illegal
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;

  logic pc_wr, ir_wr, reg_wr, mem_wr, lvl_en, jump_id;
  logic dec_regdst, dec_sign, dec_jump, dec_branch, dec_memtoreg, dec_alusrc;
  logic [2:0] dec_aluop;

  function automatic logic op_known(input logic [5:0] op);
    return (op == OP_R) || (op == OP_ADDI) || (op == OP_ORI) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_BEQ) || (op == OP_J);
  endfunction

  always_comb begin
    dec_regdst   = 1'b0;
    dec_sign     = 1'b0;
    dec_jump     = 1'b0;
    dec_branch   = 1'b0;
    dec_memtoreg = 1'b0;
    dec_alusrc   = 1'b0;
    dec_aluop    = 3'b000;
    case (op_q)
      OP_R:    begin dec_regdst = 1'b1; dec_aluop = 3'b010; end
      OP_ADDI: begin dec_sign = 1'b1; dec_alusrc = 1'b1; end
      OP_ORI:  begin dec_alusrc = 1'b1; dec_aluop = 3'b011; end
      OP_LW:   begin dec_sign = 1'b1; dec_alusrc = 1'b1; dec_memtoreg = 1'b1; end
      OP_SW:   begin dec_sign = 1'b1; dec_alusrc = 1'b1; end
      OP_BEQ:  begin dec_sign = 1'b1; dec_branch = 1'b1; dec_aluop = 3'b001; end
      OP_J:    dec_jump = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    pc_wr     = 1'b0;
    ir_wr     = 1'b0;
    reg_wr    = 1'b0;
    mem_wr    = 1'b0;
    lvl_en    = 1'b0;
    jump_id   = 1'b0;
    case (state_q)
      S_IF: begin
        ir_wr   = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        op_d = OPcode;
        // j and illegal opcodes commit here, so decode the live opcode rather than op_q
        if (OPcode == OP_J) begin
          pc_wr   = 1'b1;
          jump_id = 1'b1;
          state_d = S_IF;
        end else if (!op_known(OPcode)) begin
          pc_wr     = 1'b1;
          illegal_d = 1'b1;
          state_d   = S_IF;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        lvl_en = 1'b1;
        if (op_q == OP_BEQ) begin
          pc_wr   = 1'b1;
          state_d = S_IF;
        end else if (op_q == OP_LW || op_q == OP_SW) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        lvl_en = 1'b1;
        if (op_q == OP_SW) begin
          mem_wr  = 1'b1;
          pc_wr   = 1'b1;
          state_d = S_IF;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        lvl_en  = 1'b1;
        reg_wr  = 1'b1;
        pc_wr   = 1'b1;
        state_d = S_IF;
      end
      default: state_d = S_IF;
    endcase
    if (hold) begin
      state_d   = state_q;
      op_d      = op_q;
      illegal_d = illegal_q;
      pc_wr     = 1'b0;
      ir_wr     = 1'b0;
      reg_wr    = 1'b0;
      mem_wr    = 1'b0;
    end
    if (pc_wr) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IF;
      op_q      <= 6'b000000;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  // Reset masks every output, including write enables from a not-yet-reset state
  always_comb begin
    PCWr       = !rst && pc_wr;
    IRWr       = !rst && ir_wr;
    REgWrite   = !rst && reg_wr;
    MEmWrite   = !rst && mem_wr;
    REgDst     = !rst && lvl_en && dec_regdst;
    SIgn       = !rst && lvl_en && dec_sign;
    JUmp       = !rst && ((lvl_en && dec_jump) || jump_id);
    BRanch     = !rst && lvl_en && dec_branch;
    MEmtoReg   = !rst && lvl_en && dec_memtoreg;
    ALUSRc     = !rst && lvl_en && dec_alusrc;
    ALUOP      = (!rst && lvl_en) ? dec_aluop : 3'b000;
    retire_cnt = rst ? '0 : cnt_q;
    illegal    = !rst && illegal_q;
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - scoreboard bench for mc_ctrl with a per-instruction phase reference model
module tb_mc_ctrl;

  localparam logic [5:0] R = 6'b000000, ADDI = 6'b001000, ORI = 6'b001101, LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011, BEQ = 6'b000100, J = 6'b000010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hold = 1'b0;
  logic [5:0] OPcode = 6'b0;
  logic PCWr, IRWr, REgDst, SIgn, JUmp, BRanch, MEmtoReg, MEmWrite, ALUSRc, REgWrite, illegal;
  logic [2:0] ALUOP;
  logic [31:0] retire_cnt;

  mc_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .OPcode(OPcode), .hold(hold),
    .PCWr(PCWr), .IRWr(IRWr), .REgDst(REgDst), .SIgn(SIgn), .JUmp(JUmp),
    .BRanch(BRanch), .MEmtoReg(MEmtoReg), .ALUOP(ALUOP), .MEmWrite(MEmWrite),
    .ALUSRc(ALUSRc), .REgWrite(REgWrite), .retire_cnt(retire_cnt), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [12:0] ctl;
    logic [31:0] cnt;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;

  int          m_ph  = 0;
  logic [31:0] m_cnt = 0;
  logic        m_ill = 0;

  function automatic logic legal(input logic [5:0] op);
    return op == R || op == ADDI || op == ORI || op == LW || op == SW || op == BEQ || op == J;
  endfunction

  // instruction length in cycles
  function automatic int nph(input logic [5:0] op);
    if (op == J || !legal(op)) return 2;
    if (op == BEQ) return 3;
    if (op == LW) return 5;
    return 4;
  endfunction

  // phase at step i: 0 IF, 1 ID, 2 EXE, 3 MEM, 4 WB
  function automatic int ph_at(input logic [5:0] op, input int i);
    if (i < 3) return i;
    if (i == 3) return (op == LW || op == SW) ? 3 : 4;
    return 4;
  endfunction

  // {REgDst, SIgn, JUmp, BRanch, MEmtoReg, ALUOP, ALUSRc}
  function automatic logic [8:0] lvl(input logic [5:0] op);
    case (op)
      R:    return 9'b1_0_0_0_0_010_0;
      ADDI: return 9'b0_1_0_0_0_000_1;
      ORI:  return 9'b0_0_0_0_0_011_1;
      LW:   return 9'b0_1_0_0_1_000_1;
      SW:   return 9'b0_1_0_0_0_000_1;
      BEQ:  return 9'b0_1_0_1_0_001_0;
      J:    return 9'b0_0_1_0_0_000_0;
      default: return 9'b0;
    endcase
  endfunction

  task automatic cycle(input logic r, input logic h, input logic [5:0] op);
    exp_t e;
    int   p;
    logic last, pc, ir, rw, mw;
    logic [8:0] lv;
    @(posedge clk);
    #1;
    rst = r; hold = h; OPcode = op;
    e = '0;
    if (r) begin
      q.push_back(e);
      m_ph = 0; m_cnt = 0; m_ill = 0;
    end else begin
      p    = ph_at(op, m_ph);
      last = (m_ph == nph(op) - 1);
      ir = (p == 0); rw = (p == 4); mw = (p == 3 && op == SW); pc = last;
      if (p >= 2) lv = lvl(op);
      else if (p == 1 && op == J) lv = lvl(J);
      else lv = 9'b0;
      if (h) begin pc = 0; ir = 0; rw = 0; mw = 0; end
      e.ctl = {pc, ir, lv[8:1], mw, lv[0], rw};
      e.cnt = m_cnt;
      e.ill = m_ill;
      q.push_back(e);
      if (!h) begin
        if (p == 1 && !legal(op)) m_ill = 1;
        if (last) begin m_cnt = m_cnt + 1; m_ph = 0; end
        else m_ph = m_ph + 1;
      end
    end
  endtask

  task automatic instr(input logic [5:0] op, input int hph, input int hn, input int rph);
    for (int i = 0; i < nph(op); i++) begin
      if (i == rph) begin
        cycle(1, 0, op);
        return;
      end
      if (i == hph) for (int k = 0; k < hn; k++) cycle(0, 1, op);
      cycle(0, 0, op);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [12:0] act;
    if (q.size() > 0) begin
      e   = q.pop_front();
      act = {PCWr, IRWr, REgDst, SIgn, JUmp, BRanch, MEmtoReg, ALUOP, MEmWrite, ALUSRc, REgWrite};
      n_cmp++;
      if (act !== e.ctl) begin
        n_err++;
        $display("FAIL ctl @%0t: got %b want %b (PCWr IRWr RD SI JU BR M2R ALUOP MW AS RW)", $time, act, e.ctl);
      end
      n_cmp++;
      if (retire_cnt !== e.cnt) begin
        n_err++;
        $display("FAIL retire_cnt @%0t: got %0d want %0d", $time, retire_cnt, e.cnt);
      end
      n_cmp++;
      if (illegal !== e.ill) begin
        n_err++;
        $display("FAIL illegal @%0t: got %b want %b", $time, illegal, e.ill);
      end
    end
  end

  initial begin
    logic [5:0] ops [7];
    logic [5:0] op;
    int hph, rph;
    ops = '{R, ADDI, ORI, LW, SW, BEQ, J};
    cycle(1, 0, R);
    cycle(1, 0, R);
    instr(R, -1, 0, -1);
    instr(LW, -1, 0, -1);
    instr(SW, -1, 0, -1);
    instr(BEQ, -1, 0, -1);
    instr(J, -1, 0, -1);
    instr(ADDI, 2, 3, -1);
    instr(6'b111111, -1, 0, -1);
    instr(ORI, -1, 0, -1);
    instr(LW, -1, 0, 3);
    instr(R, 0, 2, -1);
    cycle(1, 1, SW);
    instr(SW, 3, 1, -1);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do op = 6'($urandom); while (legal(op));
      end else begin
        op = ops[$urandom_range(0, 6)];
      end
      hph = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
      rph = ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 4)) : -1;
      instr(op, hph, int'($urandom_range(1, 3)), rph);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
